// File: rtl/panda_timer_pkg.sv
// panda_timer_pkg: register offsets, CTRL layout and byte-lane merge for panda_dbus_timer
package panda_timer_pkg;

    typedef enum logic [2:0] {
        REG_CTRL     = 3'd0,
        REG_STATUS   = 3'd1,
        REG_MTIME_LO = 3'd2,
        REG_MTIME_HI = 3'd3,
        REG_CMP_LO   = 3'd4,
        REG_CMP_HI   = 3'd5,
        REG_PRESCALE = 3'd6
    } reg_offset_e;

    typedef struct packed {
        logic irq_en;
        logic en;
    } ctrl_t;

    localparam logic [63:0] CmpResetVal = '1;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_val, input logic [31:0] wdata,
                                               input logic [3:0] we);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = we[i] ? wdata[8*i +: 8] : old_val[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/panda_prescaler.sv
// panda_prescaler: tick generator counting 0..limit_i while enabled, tick_o on the wrap
//   clk_i, rst_i : clock, synchronous active-high reset
//   en_i         : count enable (counter holds when low)
//   clr_i        : restart the count from 0
//   limit_i      : terminal count; 0 gives a tick every enabled cycle
//   tick_o       : high in the cycle the counter wraps
module panda_prescaler #(
    parameter int Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [Width-1:0] limit_i,
    output logic             tick_o
);
    logic [Width-1:0] r_cnt;

    assign tick_o = en_i && (r_cnt == limit_i);

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) r_cnt <= '0;
        else if (en_i)      r_cnt <= tick_o ? '0 : r_cnt + Width'(1);
    end
endmodule

// File: rtl/panda_dbus_timer.sv
// panda_dbus_timer: data-bus timer with 64-bit MTIME, MTIMECMP, sticky match flag and level irq
//   clk_i, rst_i  : clock, synchronous active-high reset
//   sel_i         : decoder select for this cycle's access
//   data_addr_i   : byte address, word offset in [4:2]
//   data_wdata_i  : write data
//   data_we_i     : per-byte write enables
//   data_rdata_o  : registered read data (read-first), 0 when unselected
//   irq_o         : PENDING & CTRL.irq_en
module panda_dbus_timer
    import panda_timer_pkg::*;
#(
    parameter int          PrescaleWidth = 16,
    parameter logic [63:0] MtimeInit     = 64'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sel_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    input  logic [3:0]  data_we_i,
    output logic [31:0] data_rdata_o,
    output logic        irq_o
);
    ctrl_t                    r_ctrl;
    logic                     r_pending;
    logic [63:0]              r_mtime;
    logic [63:0]              r_cmp;
    logic [PrescaleWidth-1:0] r_prescale;
    logic [31:0]              r_rdata;

    logic [2:0]  w_off;
    logic [7:0]  w_hit;
    logic        w_tick;
    logic        w_w1c;
    logic [31:0] w_rd;
    logic [31:0] w_pre32;
    logic        w_unused;

    assign w_off    = data_addr_i[4:2];
    assign w_hit    = (sel_i && |data_we_i) ? 8'(1) << w_off : '0;
    assign w_w1c    = w_hit[REG_STATUS] && data_we_i[0] && data_wdata_i[0];
    assign w_pre32  = 32'(r_prescale);
    assign w_unused = ^{data_addr_i[31:5], data_addr_i[1:0]};

    panda_prescaler #(.Width(PrescaleWidth)) u_prescaler (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (r_ctrl.en),
        .clr_i   (w_hit[REG_PRESCALE]),
        .limit_i (r_prescale),
        .tick_o  (w_tick)
    );

    always_comb begin
        w_rd = '0;
        case (w_off)
            REG_CTRL:     w_rd = {30'd0, r_ctrl};
            REG_STATUS:   w_rd = {31'd0, r_pending};
            REG_MTIME_LO: w_rd = r_mtime[31:0];
            REG_MTIME_HI: w_rd = r_mtime[63:32];
            REG_CMP_LO:   w_rd = r_cmp[31:0];
            REG_CMP_HI:   w_rd = r_cmp[63:32];
            REG_PRESCALE: w_rd = w_pre32;
            default:      w_rd = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ctrl     <= '0;
            r_pending  <= 1'b0;
            r_mtime    <= MtimeInit;
            r_cmp      <= CmpResetVal;
            r_prescale <= '0;
            r_rdata    <= '0;
        end else begin
            if (w_hit[REG_CTRL] && data_we_i[0]) r_ctrl <= ctrl_t'(data_wdata_i[1:0]);
            // a still-true compare beats a same-cycle clear
            r_pending  <= (r_mtime >= r_cmp) || (r_pending && !w_w1c);
            // software writes take precedence over the tick increment
            r_mtime    <= w_hit[REG_MTIME_LO] ? {r_mtime[63:32], lane_merge(r_mtime[31:0], data_wdata_i, data_we_i)} :
                          w_hit[REG_MTIME_HI] ? {lane_merge(r_mtime[63:32], data_wdata_i, data_we_i), r_mtime[31:0]} :
                          r_mtime + 64'(w_tick);
            r_cmp      <= w_hit[REG_CMP_LO] ? {r_cmp[63:32], lane_merge(r_cmp[31:0], data_wdata_i, data_we_i)} :
                          w_hit[REG_CMP_HI] ? {lane_merge(r_cmp[63:32], data_wdata_i, data_we_i), r_cmp[31:0]} :
                          r_cmp;
            r_prescale <= w_hit[REG_PRESCALE] ? PrescaleWidth'(lane_merge(w_pre32, data_wdata_i, data_we_i)) :
                          r_prescale;
            r_rdata    <= sel_i ? w_rd : '0;
        end
    end

    assign data_rdata_o = r_rdata;
    assign irq_o        = r_pending & r_ctrl.irq_en;
endmodule

// File: tb/tb_panda_dbus_timer.sv
// tb_panda_dbus_timer: vector table, corner sequences and random traffic against a reference model
module tb_panda_dbus_timer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  we = '0;
    logic [31:0] rdata;
    logic        irq;

    int total = 0;
    int bad = 0;

    longint unsigned m_mtime;
    longint unsigned m_cmp;
    logic [1:0]      m_ctrl;
    bit              m_pend;
    int unsigned     m_pre;
    int unsigned     m_cnt;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  w;
        logic [31:0] rd;
        logic        ir;
    } vec_t;
    vec_t tbl[16];

    always #5 clk = ~clk;

    panda_dbus_timer dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .sel_i        (sel),
        .data_addr_i  (addr),
        .data_wdata_i (wdata),
        .data_we_i    (we),
        .data_rdata_o (rdata),
        .irq_o        (irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] d, input logic [3:0] w);
        logic [31:0] r = o;
        for (int b = 0; b < 4; b++) if (w[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] o);
        case (o)
            3'd0: return {30'd0, m_ctrl};
            3'd1: return {31'd0, m_pend};
            3'd2: return m_mtime[31:0];
            3'd3: return m_mtime[63:32];
            3'd4: return m_cmp[31:0];
            3'd5: return m_cmp[63:32];
            3'd6: return m_pre;
            default: return 32'd0;
        endcase
    endfunction

    function automatic void m_reset();
        m_mtime = 0;
        m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
        m_ctrl = 0;
        m_pend = 0;
        m_pre = 0;
        m_cnt = 0;
    endfunction

    task automatic cyc(input logic s, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                       input logic r = 1'b0);
        logic [31:0] exp_rd;
        logic [2:0]  o;
        bit          wr, tk, np;
        rst = r; sel = s; addr = a; wdata = d; we = w;
        @(posedge clk);
        o  = a[4:2];
        wr = s && (w != 0);
        if (r) begin
            m_reset();
            exp_rd = 0;
        end else begin
            exp_rd = s ? m_read(o) : 32'd0;
            np = (m_mtime >= m_cmp) || (m_pend && !(wr && o == 3'd1 && w[0] && d[0]));
            tk = 0;
            if (m_ctrl[0]) begin
                m_cnt = (m_cnt + 1) % (m_pre + 1);
                tk = (m_cnt == 0);
            end
            if (wr && o == 3'd6) m_cnt = 0;
            if (wr && o == 3'd2)      m_mtime[31:0]  = mrg(m_mtime[31:0], d, w);
            else if (wr && o == 3'd3) m_mtime[63:32] = mrg(m_mtime[63:32], d, w);
            else                      m_mtime += 64'(tk);
            if (wr && o == 3'd0 && w[0]) m_ctrl = d[1:0];
            if (wr && o == 3'd4) m_cmp[31:0]  = mrg(m_cmp[31:0], d, w);
            if (wr && o == 3'd5) m_cmp[63:32] = mrg(m_cmp[63:32], d, w);
            if (wr && o == 3'd6) m_pre = mrg(m_pre, d, w) & 32'hFFFF;
            m_pend = np;
        end
        #1;
        chk("model_rdata", rdata, exp_rd);
        chk("model_irq", {31'd0, irq}, {31'd0, m_pend & m_ctrl[1]});
        rst = 1'b0;
    endtask

    task automatic do_reset();
        cyc(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
    endtask
    task automatic wr(input int off, input logic [31:0] d, input logic [3:0] w = 4'hF);
        cyc(1'b1, 32'(off) << 2, d, w);
    endtask
    task automatic rd(input int off);
        cyc(1'b1, 32'(off) << 2, 32'd0, 4'd0);
    endtask
    task automatic idle();
        cyc(1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    initial begin
        logic [31:0] v0, v1;
        int first;
        m_reset();

        tbl[0]  = '{1'b1, 32'h10, 32'h0,        4'h0, 32'hFFFF_FFFF, 1'b0};
        tbl[1]  = '{1'b1, 32'h04, 32'h0,        4'h0, 32'h0,         1'b0};
        tbl[2]  = '{1'b1, 32'h14, 32'h0,        4'h0, 32'hFFFF_FFFF, 1'b0};
        tbl[3]  = '{1'b1, 32'h10, 32'hAABBCCDD, 4'h5, 32'hFFFF_FFFF, 1'b0};
        tbl[4]  = '{1'b1, 32'h10, 32'h0,        4'h0, 32'hFFBB_FFDD, 1'b0};
        tbl[5]  = '{1'b1, 32'h13, 32'h0,        4'h0, 32'hFFBB_FFDD, 1'b0};
        tbl[6]  = '{1'b1, 32'h1C, 32'h12345678, 4'hF, 32'h0,         1'b0};
        tbl[7]  = '{1'b1, 32'h1C, 32'h0,        4'h0, 32'h0,         1'b0};
        tbl[8]  = '{1'b0, 32'h10, 32'h0,        4'h0, 32'h0,         1'b0};
        tbl[9]  = '{1'b1, 32'h00, 32'hFFFFFFFE, 4'hF, 32'h0,         1'b0};
        tbl[10] = '{1'b1, 32'h00, 32'h0,        4'h0, 32'h2,         1'b0};
        tbl[11] = '{1'b1, 32'h18, 32'h00ABCDEF, 4'hF, 32'h0,         1'b0};
        tbl[12] = '{1'b1, 32'h18, 32'h0,        4'h0, 32'h0000_CDEF, 1'b0};
        tbl[13] = '{1'b1, 32'h08, 32'h0,        4'h0, 32'h0,         1'b0};
        tbl[14] = '{1'b1, 32'h0C, 32'h0,        4'h0, 32'h0,         1'b0};
        tbl[15] = '{1'b1, 32'h04, 32'h1,        4'h1, 32'h0,         1'b0};

        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].s, tbl[i].a, tbl[i].d, tbl[i].w);
            chk($sformatf("vec%0d_rdata", i), rdata, tbl[i].rd);
            chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, tbl[i].ir});
        end

        do_reset();
        wr(6, 3);
        wr(0, 1);
        repeat (40) idle();
        rd(2);
        total++;
        if (rdata < 9 || rdata > 11) begin
            bad++;
            $display("FAIL count_presc3: got %0d expected 10", rdata);
        end
        wr(6, 0);
        rd(2);
        v0 = rdata;
        rd(2);
        v1 = rdata;
        chk("count_presc0", v1 - v0, 32'd1);

        do_reset();
        wr(6, 0);
        wr(3, 0);
        wr(2, 32'hFFFF_FFFE);
        wr(0, 1);
        idle();
        idle();
        rd(3);
        chk("carry_hi", rdata, 32'd1);
        rd(2);
        chk("carry_lo", rdata, 32'd1);

        do_reset();
        wr(5, 32'hFFFF_FFFF);
        wr(4, 20);
        wr(5, 0);
        wr(2, 0);
        wr(3, 0);
        wr(6, 0);
        wr(0, 3);
        first = 0;
        for (int i = 1; i <= 100 && first == 0; i++) begin
            idle();
            if (irq) first = i;
        end
        chk("irq_rise_cycle", 32'(first), 32'd21);
        wr(1, 1);
        chk("irq_w1c_still_match", {31'd0, irq}, 32'd1);
        wr(5, 32'hFFFF_FFFF);
        wr(1, 1);
        chk("irq_cleared", {31'd0, irq}, 32'd0);

        do_reset();
        wr(6, 0);
        wr(0, 1);
        idle();
        wr(2, 32'h100);
        rd(2);
        chk("collision", rdata, 32'h100);
        rd(7);
        chk("reserved_rd", rdata, 32'h0);
        cyc(1'b0, 32'h8, 32'h0, 4'h0);
        chk("unsel_rd", rdata, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            logic [2:0]  o;
            logic [31:0] d;
            logic [3:0]  w;
            o = 3'($urandom_range(0, 7));
            d = $urandom;
            if (o == 3'd6) d = $urandom_range(0, 5);
            if (o == 3'd3 || o == 3'd5) d = $urandom_range(0, 1);
            if (o == 3'd4 || o == 3'd2) d = $urandom_range(0, 300);
            w = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
            cyc(1'($urandom), {27'd0, o, 2'($urandom)}, d, w, $urandom_range(0, 99) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
